// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction
// memory (slave): valid/ready request channel plus a valid-only response
// channel carrying either a data word or a bus error.
interface fetch_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the multicycle RV32I core.
// Owns the architectural PC and the instruction register, issues one word
// read per instruction, and raises a fetch fault on misaligned redirect
// targets or instruction-memory bus errors. Every output is a flop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk_i,
    input  logic                reset_i,
    fetch_unit_if.master        imem,
    input  logic                pc_we_i,
    input  logic [31:0]         next_pc_i,
    output logic [31:0]         pc_o,
    output logic [31:0]         ir_o,
    output logic                ir_valid_o,
    output logic                fetch_fault_o,
    output logic                fetch_fault_cause_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic CAUSE_MISALIGNED = 1'b0;
    localparam logic CAUSE_BUS_ERR    = 1'b1;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_req_valid;
    logic        r_ir_valid;
    logic        r_fault;
    logic        r_cause;

    // A redirect target is usable only if it is word aligned.
    logic        w_target_aligned;
    assign w_target_aligned = (next_pc_i[1:0] == 2'b00);

    // Fetch FSM: state, PC, IR and all registered outputs advance together.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_ir        <= NOP_INSTR;
            r_req_valid <= 1'b0;
            r_ir_valid  <= 1'b0;
            r_fault     <= 1'b0;
            r_cause     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Single settling cycle after reset, then fetch RESET_PC.
                    r_state     <= S_REQ;
                    r_req_valid <= 1'b1;
                end
                S_REQ: begin
                    // Request stays up with a stable address until accepted.
                    if (imem.req_ready) begin
                        r_state     <= S_WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // Redirects are not accepted while a read is outstanding.
                    if (imem.rsp_valid) begin
                        if (imem.rsp_err) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                            r_cause <= CAUSE_BUS_ERR;
                        end else begin
                            r_state    <= S_VALID;
                            r_ir       <= imem.rsp_data;
                            r_ir_valid <= 1'b1;
                        end
                    end
                end
                S_VALID: begin
                    if (pc_we_i) begin
                        r_ir_valid <= 1'b0;
                        if (w_target_aligned) begin
                            r_state     <= S_REQ;
                            r_pc        <= next_pc_i;
                            r_req_valid <= 1'b1;
                        end else begin
                            // PC keeps the faulting instruction's address.
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                            r_cause <= CAUSE_MISALIGNED;
                        end
                    end
                end
                S_FAULT: begin
                    // Only an aligned redirect recovers from a fault.
                    if (pc_we_i) begin
                        if (w_target_aligned) begin
                            r_state     <= S_REQ;
                            r_pc        <= next_pc_i;
                            r_req_valid <= 1'b1;
                            r_fault     <= 1'b0;
                        end else begin
                            r_cause <= CAUSE_MISALIGNED;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_valid <= 1'b0;
                    r_ir_valid  <= 1'b0;
                    r_fault     <= 1'b0;
                end
            endcase
        end
    end

    assign imem.req_valid      = r_req_valid;
    assign imem.addr           = r_pc;
    assign pc_o                = r_pc;
    assign ir_o                = r_ir;
    assign ir_valid_o          = r_ir_valid;
    assign fetch_fault_o       = r_fault;
    assign fetch_fault_cause_o = r_cause;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: walks the FSM through reset, fetch,
// stalled request, redirect, misaligned redirect, bus error and mid-flight
// reset, checking registered outputs 1 ns after each rising edge.
module tb_fetch_unit;

    logic        clk_i;
    logic        reset_i;
    logic        pc_we_i;
    logic [31:0] next_pc_i;
    logic [31:0] pc_o;
    logic [31:0] ir_o;
    logic        ir_valid_o;
    logic        fetch_fault_o;
    logic        fetch_fault_cause_o;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .imem                (bus.master),
        .pc_we_i             (pc_we_i),
        .next_pc_i           (next_pc_i),
        .pc_o                (pc_o),
        .ir_o                (ir_o),
        .ir_valid_o          (ir_valid_o),
        .fetch_fault_o       (fetch_fault_o),
        .fetch_fault_cause_o (fetch_fault_cause_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    int hs_base  = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Count accepted requests on the bus.
    always @(posedge clk_i) begin
        if (!reset_i && bus.req_valid && bus.req_ready) n_hs <= n_hs + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},       pc_o, 32'h0000_0000);
        chk({tag, "_ir"},       ir_o, 32'h0000_0013);
        chk({tag, "_irv"},      {31'd0, ir_valid_o}, 32'd0);
        chk({tag, "_reqv"},     {31'd0, bus.req_valid}, 32'd0);
        chk({tag, "_fault"},    {31'd0, fetch_fault_o}, 32'd0);
        chk({tag, "_cause"},    {31'd0, fetch_fault_cause_o}, 32'd0);
    endtask

    initial begin
        reset_i       = 1'b1;
        pc_we_i       = 1'b0;
        next_pc_i     = 32'h0;
        bus.req_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = 32'h0;
        bus.rsp_err   = 1'b0;

        // Reset values while reset is held.
        step();
        step();
        chk_reset_vals("rst");

        // Release: one IDLE cycle, then request at 0x0 accepted at once.
        reset_i = 1'b0;
        step();
        chk("idle_reqv", {31'd0, bus.req_valid}, 32'd1);
        chk("req0_addr", bus.addr, 32'h0000_0000);
        step();
        chk("wait0_reqv", {31'd0, bus.req_valid}, 32'd0);
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'h0050_0093;
        step();
        bus.rsp_valid = 1'b0;
        chk("v0_ir",  ir_o, 32'h0050_0093);
        chk("v0_pc",  pc_o, 32'h0000_0000);
        chk("v0_irv", {31'd0, ir_valid_o}, 32'd1);
        step();
        chk("v0_hold_ir",  ir_o, 32'h0050_0093);
        chk("v0_hold_irv", {31'd0, ir_valid_o}, 32'd1);

        // Redirect to 0x104 with memory stalling the request for 3 cycles.
        bus.req_ready = 1'b0;
        pc_we_i       = 1'b1;
        next_pc_i     = 32'h0000_0104;
        step();
        pc_we_i = 1'b0;
        hs_base = n_hs;
        chk("redir_irv",  {31'd0, ir_valid_o}, 32'd0);
        chk("redir_pc",   pc_o, 32'h0000_0104);
        chk("redir_reqv", {31'd0, bus.req_valid}, 32'd1);
        chk("redir_addr", bus.addr, 32'h0000_0104);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_reqv", {31'd0, bus.req_valid}, 32'd1);
            chk("stall_addr", bus.addr, 32'h0000_0104);
        end
        bus.req_ready = 1'b1;
        step();
        chk("stall_hs_cnt", n_hs - hs_base, 32'd1);
        chk("stall_wait_reqv", {31'd0, bus.req_valid}, 32'd0);

        // Redirect attempts during WAIT are ignored.
        pc_we_i   = 1'b1;
        next_pc_i = 32'h0000_0300;
        step();
        step();
        pc_we_i = 1'b0;
        chk("wait_pc_hold", pc_o, 32'h0000_0104);
        chk("wait_reqv",    {31'd0, bus.req_valid}, 32'd0);
        chk("wait_irv",     {31'd0, ir_valid_o}, 32'd0);
        chk("wait_hs_cnt",  n_hs - hs_base, 32'd1);

        // Bus error response.
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = 1'b1;
        bus.rsp_data  = 32'hFFFF_FFFF;
        step();
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        chk("berr_fault", {31'd0, fetch_fault_o}, 32'd1);
        chk("berr_cause", {31'd0, fetch_fault_cause_o}, 32'd1);
        chk("berr_ir",    ir_o, 32'h0050_0093);
        chk("berr_irv",   {31'd0, ir_valid_o}, 32'd0);

        // Recover with aligned redirect to 0x108 and fetch a new word.
        pc_we_i   = 1'b1;
        next_pc_i = 32'h0000_0108;
        step();
        pc_we_i = 1'b0;
        chk("rec_fault", {31'd0, fetch_fault_o}, 32'd0);
        chk("rec_addr",  bus.addr, 32'h0000_0108);
        step();
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'h00A0_0113;
        step();
        bus.rsp_valid = 1'b0;
        chk("v1_ir",  ir_o, 32'h00A0_0113);
        chk("v1_irv", {31'd0, ir_valid_o}, 32'd1);

        // Misaligned redirect from VALID.
        hs_base   = n_hs;
        pc_we_i   = 1'b1;
        next_pc_i = 32'h0000_0102;
        step();
        pc_we_i = 1'b0;
        chk("mis_fault", {31'd0, fetch_fault_o}, 32'd1);
        chk("mis_cause", {31'd0, fetch_fault_cause_o}, 32'd0);
        chk("mis_reqv",  {31'd0, bus.req_valid}, 32'd0);
        chk("mis_pc",    pc_o, 32'h0000_0108);
        chk("mis_irv",   {31'd0, ir_valid_o}, 32'd0);
        step();
        chk("mis_noreq", n_hs - hs_base, 32'd0);
        chk("mis_reqv2", {31'd0, bus.req_valid}, 32'd0);

        // Misaligned redirect while faulted keeps the fault.
        pc_we_i   = 1'b1;
        next_pc_i = 32'h0000_0106;
        step();
        chk("mis2_fault", {31'd0, fetch_fault_o}, 32'd1);
        chk("mis2_cause", {31'd0, fetch_fault_cause_o}, 32'd0);
        chk("mis2_pc",    pc_o, 32'h0000_0108);

        // Aligned redirect to 0x200 clears the fault.
        next_pc_i = 32'h0000_0200;
        step();
        pc_we_i = 1'b0;
        chk("f200_fault", {31'd0, fetch_fault_o}, 32'd0);
        chk("f200_reqv",  {31'd0, bus.req_valid}, 32'd1);
        chk("f200_addr",  bus.addr, 32'h0000_0200);

        // Accepted; now in WAIT. Asynchronous reset mid-transaction.
        step();
        #1;
        reset_i = 1'b1;
        #1;
        chk_reset_vals("arst");

        // Release with a stray response during IDLE and REQ.
        step();
        reset_i       = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'hDEAD_BEEF;
        step();
        chk("stray_idle_ir",  ir_o, 32'h0000_0013);
        chk("stray_reqv",     {31'd0, bus.req_valid}, 32'd1);
        step();
        chk("stray_req_ir",   ir_o, 32'h0000_0013);
        chk("stray_req_irv",  {31'd0, ir_valid_o}, 32'd0);
        bus.rsp_valid = 1'b0;
        bus.req_ready = 1'b1;
        step();
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'h0010_0073;
        step();
        bus.rsp_valid = 1'b0;
        chk("post_rst_ir",  ir_o, 32'h0010_0073);
        chk("post_rst_pc",  pc_o, 32'h0000_0000);
        chk("post_rst_irv", {31'd0, ir_valid_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
